// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: block-fill engine for cache misses; optional FILL_TIMEOUT_EN adds a fill watchdog
module cache_fill_fsm #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    input  logic                               memory_data_valid,
    input  logic [DATA_W-1:0]                  memory_data,
    output logic                               fsm_busy,
    output logic                               memory_read_en,
    output logic [ADDR_W-1:0]                  memory_address,
    output logic                               write_data_array,
    output logic                               write_tag_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_offset,
    output logic [DATA_W-1:0]                  fill_data,
    output logic                               fill_error
);
    localparam int OW = $clog2(WORDS_PER_BLOCK);
    localparam int CW = OW + 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] base, base_next;
    logic [CW-1:0]     issue_cnt, issue_next, ret_cnt, ret_next;

`ifdef FILL_TIMEOUT_EN
    localparam int WDW = $clog2(2 * MEM_LATENCY) > 0 ? $clog2(2 * MEM_LATENCY) : 1;
    logic [WDW-1:0] wd, wd_next;

    always_ff @(posedge clk) begin
        if (rst) wd <= '0;
        else     wd <= wd_next;
    end
`else
    logic unused_latency;
    assign unused_latency = MEM_LATENCY > 0;
`endif

    assign fill_data = memory_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            state     <= state_next;
            base      <= base_next;
            issue_cnt <= issue_next;
            ret_cnt   <= ret_next;
        end
    end

    always_comb begin
        state_next       = state;
        base_next        = base;
        issue_next       = issue_cnt;
        ret_next         = ret_cnt;
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        data_word_offset = '0;
        fill_error       = 1'b0;
`ifdef FILL_TIMEOUT_EN
        wd_next = (state == FILL && !memory_data_valid) ? wd + WDW'(1) : '0;
`endif
        if (state == IDLE) begin
            fsm_busy = miss_detected;
            if (miss_detected) begin
                // block spans 2*WORDS_PER_BLOCK bytes
                base_next  = miss_address & ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
                issue_next = '0;
                ret_next   = '0;
                state_next = FILL;
            end
        end else begin
            fsm_busy       = 1'b1;
            memory_read_en = issue_cnt < CW'(WORDS_PER_BLOCK);
            if (memory_read_en) begin
                memory_address = base + ADDR_W'({issue_cnt, 1'b0});
                issue_next     = issue_cnt + CW'(1);
            end
            if (memory_data_valid) begin
                write_data_array = 1'b1;
                data_word_offset = ret_cnt[OW-1:0];
                ret_next         = ret_cnt + CW'(1);
                if (ret_cnt == CW'(WORDS_PER_BLOCK - 1)) begin
                    write_tag_array = 1'b1;
                    state_next      = IDLE;
                end
            end
`ifdef FILL_TIMEOUT_EN
            else if (wd == WDW'(2 * MEM_LATENCY - 1) && ret_cnt < CW'(WORDS_PER_BLOCK)) begin
                fill_error = 1'b1;
                state_next = IDLE;
            end
`endif
        end
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed vector table plus hand sequences for reset, 4-word blocks and timeout
module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        miss, v;
    logic [15:0] ma, d;
    logic        busy, rd, wr, tag, err;
    logic [15:0] maddr, fd;
    logic [2:0]  off;

    logic        miss4, v4;
    logic [15:0] ma4, d4;
    logic        busy4, rd4, wr4, tag4, err4;
    logic [15:0] maddr4, fd4;
    logic [1:0]  off4;

    cache_fill_fsm u_dut (
        .clk(clk), .rst(rst), .miss_detected(miss), .miss_address(ma),
        .memory_data_valid(v), .memory_data(d), .fsm_busy(busy),
        .memory_read_en(rd), .memory_address(maddr), .write_data_array(wr),
        .write_tag_array(tag), .data_word_offset(off), .fill_data(fd),
        .fill_error(err)
    );

    cache_fill_fsm #(.WORDS_PER_BLOCK(4)) u_dut4 (
        .clk(clk), .rst(rst), .miss_detected(miss4), .miss_address(ma4),
        .memory_data_valid(v4), .memory_data(d4), .fsm_busy(busy4),
        .memory_read_en(rd4), .memory_address(maddr4), .write_data_array(wr4),
        .write_tag_array(tag4), .data_word_offset(off4), .fill_data(fd4),
        .fill_error(err4)
    );

    typedef struct {
        logic        miss;
        logic [15:0] ma;
        logic        v;
        logic [15:0] d;
        logic        busy;
        logic        rd;
        logic [15:0] addr;
        logic        wr;
        logic        tag;
        logic [2:0]  off;
    } vec_t;

    vec_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic miss_i, input logic [15:0] ma_i, input logic v_i,
                        input logic [15:0] d_i, input logic busy_i, input logic rd_i,
                        input logic [15:0] addr_i, input logic wr_i, input logic tag_i,
                        input logic [2:0] off_i);
        vec_t e;
        e.miss = miss_i; e.ma = ma_i; e.v = v_i; e.d = d_i; e.busy = busy_i;
        e.rd = rd_i; e.addr = addr_i; e.wr = wr_i; e.tag = tag_i; e.off = off_i;
        q.push_back(e);
    endtask

    // Miss cycle, then 8 issues at k=1..8; word j returns at k=5+j, shifted by gap_len from word gap_at
    task automatic add_fill(input logic [15:0] mad, input logic [15:0] base, input int gap_at,
                            input int gap_len, input logic hold, input logic [15:0] nxt);
        int n, j;
        logic r, hv;
        logic [15:0] a;
        n = 12 + gap_len;
        push(1'b1, mad, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
        for (int k = 1; k <= n; k++) begin
            r = k <= 8;
            a = r ? base + 16'(2 * (k - 1)) : 16'h0;
            j = -1;
            for (int w = 0; w < 8; w++)
                if (k == 5 + w + (w >= gap_at ? gap_len : 0)) j = w;
            hv = hold && k >= n - 2;
            push(hv, hv ? nxt : 16'h0, j >= 0, j >= 0 ? 16'hA000 + 16'(j) : 16'h0,
                 1'b1, r, a, j >= 0, j == 7, j >= 0 ? 3'(j) : 3'd0);
        end
    endtask

    task automatic add_idle();
        push(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0);
    endtask

    logic [15:0] a4 [4];

    initial begin
        rst = 1'b1; miss = 0; ma = 0; v = 0; d = 0; miss4 = 0; ma4 = 0; v4 = 0; d4 = 0;
        a4[0] = 16'hFFF8; a4[1] = 16'hFFFA; a4[2] = 16'hFFFC; a4[3] = 16'hFFFE;

        add_fill(16'h1236, 16'h1230, 8, 0, 1'b0, 16'h0);
        add_idle();
        add_fill(16'h2016, 16'h2010, 5, 3, 1'b0, 16'h0);
        add_idle();
        add_fill(16'h3000, 16'h3000, 8, 0, 1'b1, 16'h4000);
        add_fill(16'h4000, 16'h4000, 8, 0, 1'b0, 16'h0);
        add_idle();

        @(posedge clk);
        @(negedge clk); #1;
        check("reset_out", {busy, rd, maddr, wr, tag, off, err}, 0);
        check("reset_out4", {busy4, rd4, maddr4, wr4, tag4, off4, err4}, 0);
        rst = 1'b0;

        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            miss = q[i].miss; ma = q[i].ma; v = q[i].v; d = q[i].d;
            #1;
            check($sformatf("vec%0d", i), {busy, rd, maddr, wr, tag, off, err, fd},
                  {q[i].busy, q[i].rd, q[i].addr, q[i].wr, q[i].tag, q[i].off, 1'b0, q[i].d});
        end

        // Reset asserted alongside the third returned word
        @(negedge clk); miss = 1; ma = 16'h1236; v = 0; d = 0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            miss = 0; v = k >= 5; d = v ? 16'hA000 + 16'(k - 5) : 16'h0;
            rst = k == 7;
            #1;
            if (k == 7) check("rst_word2", {wr, off, tag}, {1'b1, 3'd2, 1'b0});
        end
        @(negedge clk); rst = 0; v = 1; d = 16'hA003; #1;
        check("rst_abort", {busy, rd, maddr, wr, tag, off, err}, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); v = 1; d = 16'hA004 + 16'(k); #1;
            check($sformatf("rst_late%0d", k), {busy, rd, wr, tag}, 4'b0);
        end
        @(negedge clk); v = 0; d = 0;

        // 4-word block near top of the address space
        @(negedge clk); miss4 = 1; ma4 = 16'hFFFA; #1;
        check("w4_miss", {busy4, rd4, wr4}, 3'b100);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            miss4 = 0; v4 = k >= 5 && k <= 8; d4 = v4 ? 16'hB000 + 16'(k - 5) : 16'h0;
            #1;
            check($sformatf("w4_c%0d", k), {busy4, rd4, maddr4, wr4, tag4, off4, fd4},
                  {k <= 8, k <= 4, k <= 4 ? a4[k-1] : 16'h0, v4, k == 8,
                   v4 ? 2'(k - 5) : 2'd0, d4});
        end
        @(negedge clk); v4 = 0;

`ifdef FILL_TIMEOUT_EN
        @(negedge clk); miss = 1; ma = 16'h0000; #1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            miss = 0; v = k >= 5 && k <= 7; d = v ? 16'hC000 + 16'(k - 5) : 16'h0;
            #1;
            check($sformatf("wd_c%0d", k), {busy, wr, tag, err},
                  {k <= 15, k >= 5 && k <= 7, 1'b0, k == 15});
        end
        @(negedge clk); v = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Parametrised miss-handling engine that sits between a cache (I- or D-side) and a pipelined multi-cycle main memory. On a miss it stalls the core, issues one read per cycle for every word of the aligned block, and writes each returned word into the data array. It updates the tag array on the final word, then releases the stall. Block size, address/data width and memory latency are generics, so both caches share one block.

Parameters:
ADDR_W, 16, byte-address width.
DATA_W, 16, memory word width. Each word is 2 bytes; the address stride is 2.
WORDS_PER_BLOCK, 8, words per cache block; power of two, ≥2.
MEM_LATENCY, 4, cycles from a memory request to its memory_data_valid; used by the watchdog only.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous reset, active-high.
miss_detected  in  1  cache miss on the current access; level, sampled in IDLE.
miss_address  in  ADDR_W  byte address of the missing access.
memory_data_valid  in  1  memory_data holds the next returned word.
memory_data  in  DATA_W  returned word; in-order with requests.
fsm_busy  out  1  stall to the core.
memory_read_en  out  1  read request this cycle.
memory_address  out  ADDR_W  request address.
write_data_array  out  1  write fill_data at data_word_offset.
write_tag_array  out  1  write the tag/valid for the latched block.
data_word_offset  out  log2(WORDS_PER_BLOCK)  word index being written.
fill_data  out  DATA_W  word to write; a combinational pass-through of memory_data.
fill_error  out  1  one-cycle abort pulse; exists only with FILL_TIMEOUT_EN and is tied to 0 otherwise.

Behaviour:
- States: IDLE and FILL. Registers:
  - base: miss_address with its low log2(WORDS_PER_BLOCK)+1 bits cleared.
  - issue_cnt and ret_cnt: each 0..WORDS_PER_BLOCK.
- Reset: state=IDLE and all counters and base=0. Every output is 0 in the cycle after reset is sampled.
- IDLE:
  - fsm_busy = miss_detected (combinational), so the core stalls in the same cycle.
  - If miss_detected: latch base, clear both counters, go to FILL next cycle.
  - memory_data_valid is ignored; no array writes occur.
- FILL:
  - fsm_busy=1.
  - memory_read_en = (issue_cnt < WORDS_PER_BLOCK).
  - memory_address = base + 2*issue_cnt (modulo 2^ADDR_W). issue_cnt increments on each issue.
  - On memory_data_valid: write_data_array=1, data_word_offset=ret_cnt, and ret_cnt increments.
  - On the valid that carries ret_cnt==WORDS_PER_BLOCK-1: write_tag_array=1 in that same cycle, and the next state is IDLE.
  - miss_detected is ignored throughout FILL.
- Issuing and returning overlap. A valid may arrive in the same cycle as an issue; both counters update independently.
- Timing (miss sampled at cycle T, memory latency L):
  - Requests are issued at T+1..T+W.
  - The last valid and write_tag_array occur at T+W+L.
  - fsm_busy is high from T through T+W+L and low at T+W+L+1, unless a new miss is present then.
  - Defaults W=8, L=4: busy for 13 cycles.
- Back-to-back misses: the cycle after the return to IDLE may accept a new miss immediately.
- Reset in FILL: abort at once. No further writes or requests occur, and late memory_data_valid pulses are ignored because the FSM is in IDLE.
- Extra memory_data_valid pulses beyond WORDS_PER_BLOCK cannot occur in FILL, because the FSM leaves FILL on the last word.

Optional Feature:
FILL_TIMEOUT_EN:
- When defined, a watchdog counter runs in FILL. It clears on every memory_data_valid and increments otherwise.
- When it reaches 2*MEM_LATENCY while ret_cnt < WORDS_PER_BLOCK:
  - fill_error pulses for one cycle.
  - write_tag_array stays 0, so the block is left invalid.
  - The FSM returns to IDLE next cycle.
- When undefined, the watchdog is not built, fill_error is constant 0, and FILL waits indefinitely.

Test Plan:
- Basic fill, defaults: miss_address=0x1236 at T → memory_address 0x1230,0x1232,…,0x123E at T+1..T+8. Memory returns 0xA000+i at T+5..T+12 → eight writes with offsets 0..7, write_tag_array at T+12 only, fsm_busy low at T+13.
- Stalled memory: insert a 3-cycle gap in valid before word 5 → offsets remain 0..7 in order, tag written with word 7, busy extended by 3 cycles.
- Back-to-back misses: miss held high across the end of a fill with new address 0x4000 → a second fill issues from 0x4000 at the cycle after the return to IDLE, and fsm_busy shows no low gap.
- Reset mid-fill: assert rst at the 3rd returned word → all outputs 0 next cycle. Later valid pulses cause no write_data_array or write_tag_array.
- Parametrisation: WORDS_PER_BLOCK=4, ADDR_W=16, miss 0xFFFA → addresses 0xFFF8,0xFFFA,0xFFFC,0xFFFE, data_word_offset 2 bits, tag written on the 4th word.
- With FILL_TIMEOUT_EN, MEM_LATENCY=4: stop valids after word 2 → fill_error pulses 8 cycles after the last valid, write_tag_array never asserts, IDLE follows.
